// File: rtl/microgreen_result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : microgreen_result_uart_tx
//  Description : Captures one microgreen BNN classifier result per rising edge
//                of the ready bit into a small FIFO, then streams each result
//                off-chip as a 2-byte UART 8N1 frame: sync byte 0xA5 followed
//                by the raw result byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module microgreen_result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [7:0]                    res_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                  c_ADDR_W    = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0]  c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_ADDR_W:0]   c_FULL      = (c_ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]          c_SYNC      = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Result FIFO storage and bookkeeping
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_ADDR_W:0]    r_level;
    logic                 r_overflow;
    logic                 r_ready_q;

    // Transmitter state
    state_t               r_state;
    logic                 r_byte_sel;   // 0 = sync byte on the line, 1 = result byte
    logic [7:0]           r_shift;
    logic [7:0]           r_result;
    logic [2:0]           r_bit;
    logic [c_CNT_W-1:0]   r_baud;
    logic                 r_tx;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tick;

    assign w_full     = (r_level == c_FULL);
    assign w_empty    = (r_level == '0);
    assign w_push_req = ena && res_in[3] && !r_ready_q;
    assign w_pop      = ena && (r_state == S_IDLE) && !w_empty;
    // A full FIFO still accepts a push when the same cycle pops a slot free.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_tick     = (r_baud == c_BAUD_LAST);

    // FIFO data array: written at the write pointer on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= res_in;
        end
    end

    // Ready edge detection, FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_q  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (ena) begin
            r_ready_q <= res_in[3];
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (c_ADDR_W + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (c_ADDR_W + 1)'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // UART framing FSM: sync byte then result byte, 8N1, LSB first, registered tx
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_sel <= 1'b0;
            r_shift    <= '0;
            r_result   <= '0;
            r_bit      <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b1;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_result   <= r_mem[r_rd_ptr];
                        r_shift    <= c_SYNC;
                        r_byte_sel <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + c_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + c_CNT_W'(1);
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        r_baud <= '0;
                        if (!r_byte_sel) begin
                            // Sync byte done: result byte follows with no idle gap
                            r_shift    <= r_result;
                            r_byte_sel <= 1'b1;
                            r_state    <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
`default_nettype wire
